serial_subtractor: RTL and testbench

//   Inverse of the 16-bit adder datapath: given sum c and operand a, recovers b = c - a.

---
 rtl/sub_pkg.sv | 21 ++
 rtl/digit_sub.sv | 21 ++
 rtl/serial_subtractor.sv | 116 +++++++++++
 tb/tb_serial_subtractor.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the serial subtractor.
// Default-geometry constants describe the 16-bit adder companion configuration.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int ndig(input int c_w, input int digit_w);
        return (c_w + digit_w - 1) / digit_w;
    endfunction

    localparam int A_W_DEF     = 16;
    localparam int C_W_DEF     = A_W_DEF + 1;
    localparam int DIGIT_W_DEF = 4;
    localparam int NDIG        = ndig(C_W_DEF, DIGIT_W_DEF);
    localparam int PAD_W       = NDIG * DIGIT_W_DEF;

endpackage

// File: rtl/digit_sub.sv
// One digit of the borrow chain: {bout, diff} = x - y - bin.
// The extra top bit of the W+1 wide difference is the borrow out.
module digit_sub #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         bin,
    output logic [W-1:0] diff,
    output logic         bout
);

    logic [W:0] full;

    always_comb begin
        full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bin};
        diff = full[W-1:0];
        bout = full[W];
    end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial b = c - a with valid/ready handshakes on both sides.
// Recovers the adder's second operand and flags results that do not fit A_W bits.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int A_W     = A_W_DEF,
    parameter int DIGIT_W = DIGIT_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W:0]   c,
    input  logic [A_W-1:0] a,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [A_W-1:0] b,
    output logic           underflow,
    output logic           overflow
);

    localparam int C_W      = A_W + 1;
    localparam int NUM_DIG  = ndig(C_W, DIGIT_W);
    localparam int PAD_BITS = NUM_DIG * DIGIT_W;
    localparam int CNT_W    = $clog2(NUM_DIG + 1);

    state_t               state;
    state_t               state_next;
    logic [PAD_BITS-1:0]  c_sh;
    logic [PAD_BITS-1:0]  a_sh;
    logic [PAD_BITS-1:0]  diff_sh;
    logic [PAD_BITS-1:0]  diff_next;
    logic                 borrow;
    logic [CNT_W-1:0]     cnt;
    logic                 last_digit;
    logic [DIGIT_W-1:0]   digit;
    logic                 bout;

    digit_sub #(.W(DIGIT_W)) u_digit (
        .x    (c_sh[DIGIT_W-1:0]),
        .y    (a_sh[DIGIT_W-1:0]),
        .bin  (borrow),
        .diff (digit),
        .bout (bout)
    );

    // New digit enters at the top so the LSD ends up at bit 0 after NUM_DIG shifts.
    assign diff_next  = (PAD_BITS'(digit) << (PAD_BITS - DIGIT_W)) | (diff_sh >> DIGIT_W);
    assign last_digit = (cnt == CNT_W'(NUM_DIG - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last_digit) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_sh      <= '0;
            a_sh      <= '0;
            diff_sh   <= '0;
            borrow    <= 1'b0;
            cnt       <= '0;
            b         <= '0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        c_sh   <= PAD_BITS'(c);
                        a_sh   <= PAD_BITS'(a);
                        borrow <= 1'b0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    c_sh    <= c_sh >> DIGIT_W;
                    a_sh    <= a_sh >> DIGIT_W;
                    diff_sh <= diff_next;
                    borrow  <= bout;
                    cnt     <= cnt + CNT_W'(1);
                    if (last_digit) begin
                        b         <= diff_next[A_W-1:0];
                        underflow <= bout;
                        overflow  <= !bout && diff_next[A_W];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: three instances (DIGIT_W = 4, 1, 17) checked
// against plain integer subtraction of c and a.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [3];
    logic        out_ready [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic        underflow [3];
    logic        overflow  [3];
    logic [16:0] c         [3];
    logic [15:0] a         [3];
    logic [15:0] b         [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.A_W(16), .DIGIT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .c(c[0]), .a(a[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .b(b[0]), .underflow(underflow[0]), .overflow(overflow[0])
    );

    serial_subtractor #(.A_W(16), .DIGIT_W(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .c(c[1]), .a(a[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .b(b[1]), .underflow(underflow[1]), .overflow(overflow[1])
    );

    serial_subtractor #(.A_W(16), .DIGIT_W(17)) dut17 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .c(c[2]), .a(a[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .b(b[2]), .underflow(underflow[2]), .overflow(overflow[2])
    );

    function automatic int nd(input int k);
        case (k)
            0:       return sub_pkg::NDIG;
            1:       return 17;
            default: return 1;
        endcase
    endfunction

    // Present one pair, then count cycles from the accepting edge until out_valid.
    task automatic send(input int k, input logic [16:0] cv, input logic [15:0] av, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready[k] && w < 50) begin
            @(negedge clk);
            w++;
        end
        c[k] = cv;
        a[k] = av;
        in_valid[k] = 1'b1;
        @(negedge clk);
        in_valid[k] = 1'b0;
        lat = 0;
        while (!out_valid[k] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic accept(input int k, input int hold);
        repeat (hold) @(negedge clk);
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({in_ready[k], out_valid[k], b[k], underflow[k], overflow[k]} !== {1'b1, 1'b0, 16'd0, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL reset[%0d]: got ir=%b ov=%b b=%0d uf=%b of=%b, expected ir=1 ov=0 b=0 uf=0 of=0",
                         k, in_ready[k], out_valid[k], b[k], underflow[k], overflow[k]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [16:0] cv [3];
        logic [15:0] av [3];
        int lat, d;
        cv[0] = 17'd150;    av[0] = 16'd63;
        cv[1] = 17'd5;      av[1] = 16'd10;
        cv[2] = 17'h1FFFF;  av[2] = 16'd0;
        for (int k = 0; k < 3; k++) begin
            for (int v = 0; v < 3; v++) begin
                send(k, cv[v], av[v], lat);
                d = int'(cv[v]) - int'(av[v]);
                n_cmp++;
                if (lat !== nd(k)) begin
                    n_bad++;
                    $display("FAIL directed[%0d.%0d] latency: got %0d, expected %0d", k, v, lat, nd(k));
                end
                n_cmp++;
                if (b[k] !== 16'(d)) begin
                    n_bad++;
                    $display("FAIL directed[%0d.%0d] b: got %0d, expected %0d", k, v, b[k], 16'(d));
                end
                n_cmp++;
                if ({underflow[k], overflow[k]} !== {d < 0, d >= 65536}) begin
                    n_bad++;
                    $display("FAIL directed[%0d.%0d] flags uf/of: got %b%b, expected %b%b",
                             k, v, underflow[k], overflow[k], d < 0, d >= 65536);
                end
                accept(k, 0);
            end
        end
    endtask

    task automatic test_hold;
        int lat;
        send(0, 17'd1000, 16'd1, lat);
        for (int i = 0; i < 6; i++) begin
            c[0] = 17'($urandom);
            a[0] = 16'($urandom);
            in_valid[0] = 1'b1;
            @(negedge clk);
            n_cmp++;
            if ({out_valid[0], in_ready[0], b[0], underflow[0], overflow[0]} !== {1'b1, 1'b0, 16'd999, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL hold[%0d]: got ov=%b ir=%b b=%0d uf=%b of=%b, expected ov=1 ir=0 b=999 uf=0 of=0",
                         i, out_valid[0], in_ready[0], b[0], underflow[0], overflow[0]);
            end
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        in_valid[0] = 1'b0;
        n_cmp++;
        if ({out_valid[0], in_ready[0], b[0]} !== {1'b0, 1'b1, 16'd999}) begin
            n_bad++;
            $display("FAIL hold release: got ov=%b ir=%b b=%0d, expected ov=0 ir=1 b=999",
                     out_valid[0], in_ready[0], b[0]);
        end
        @(negedge clk);
        n_cmp++;
        if ({out_valid[0], in_ready[0]} !== {1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL hold ignored-input: got ov=%b ir=%b, expected ov=0 ir=1", out_valid[0], in_ready[0]);
        end
    endtask

    task automatic test_mid_reset;
        int lat;
        bit seen;
        @(negedge clk);
        c[0] = 17'h1_2345;
        a[0] = 16'h0345;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({in_ready[0], out_valid[0], b[0], underflow[0], overflow[0]} !== {1'b1, 1'b0, 16'd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL mid-run reset: got ir=%b ov=%b b=%0d uf=%b of=%b, expected ir=1 ov=0 b=0 uf=0 of=0",
                     in_ready[0], out_valid[0], b[0], underflow[0], overflow[0]);
        end
        seen = 1'b0;
        for (int i = 0; i < nd(0) + 3; i++) begin
            @(negedge clk);
            if (out_valid[0]) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL mid-run reset stray out_valid: got %b, expected 0", seen);
        end
        send(0, 17'd200, 16'd99, lat);
        n_cmp++;
        if ({lat, b[0], underflow[0], overflow[0]} !== {nd(0), 16'd101, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL post-reset op: got lat=%0d b=%0d uf=%b of=%b, expected lat=%0d b=101 uf=0 of=0",
                     lat, b[0], underflow[0], overflow[0], nd(0));
        end
        accept(0, 1);
    endtask

    task automatic test_random(input int k, input int count, input bit full);
        logic [16:0] cv;
        logic [15:0] av;
        int lat, d, bad_before;
        bad_before = n_bad;
        for (int i = 0; i < count; i++) begin
            if (full) begin
                cv = 17'($urandom_range(0, 131071));
                av = 16'($urandom_range(0, 65535));
            end else begin
                av = 16'($urandom_range(0, 99));
                cv = 17'(av) + 17'($urandom_range(0, 99));
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(k, cv, av, lat);
            d = int'(cv) - int'(av);
            n_cmp++;
            if ({lat, b[k], underflow[k], overflow[k]} !== {nd(k), 16'(d), d < 0, d >= 65536}) begin
                n_bad++;
                if (n_bad - bad_before <= 5)
                    $display("FAIL random[%0d] c=%0d a=%0d: got lat=%0d b=%0d uf=%b of=%b, expected lat=%0d b=%0d uf=%b of=%b",
                             k, cv, av, lat, b[k], underflow[k], overflow[k], nd(k), 16'(d), d < 0, d >= 65536);
            end
            accept(k, $urandom_range(0, 3));
        end
    endtask

    initial begin
        $display("tb_serial_subtractor: default NDIG=%0d PAD_W=%0d", sub_pkg::NDIG, sub_pkg::PAD_W);
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            c[k]         = '0;
            a[k]         = '0;
        end
        test_reset;
        test_directed;
        test_hold;
        test_mid_reset;
        for (int k = 0; k < 3; k++) test_random(k, 100, 1'b0);
        for (int k = 0; k < 3; k++) test_random(k, 40, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
